data_memory_unit: RTL and testbench

//  Parametrised, synchronous data memory for the MIPS-32 datapath. Serves load/store

---
 rtl/data_memory_unit_pkg.sv | 33 +++
 rtl/data_memory_unit_if.sv | 27 ++
 rtl/data_memory_unit_lane_align.sv | 38 +++
 rtl/data_memory_unit.sv | 165 ++++++++++++++++
 tb/tb_data_memory_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared definitions for the MIPS-32 data memory: access size encodings,
// FSM state type, captured-request struct and lane-enable helper.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// rsp_valid is a one-cycle pulse, rsp_rdata/rsp_err hold until the next pulse.
interface data_memory_unit_if #(
    parameter int ADDR_W = 18
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_unit_lane_align.sv
// Combinational lane steering: replicates store data onto byte lanes and
// extracts/extends load data from the read word (little-endian lanes).
module dmem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        lane_wdata = wdata;
        case (size)
            SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
            SZ_HALF: lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = wdata;
        endcase
    end

    always_comb begin
        byte_sel = rword[8*offset +: 8];
        half_sel = offset[1] ? rword[31:16] : rword[15:0];
        rdata    = rword;
        case (size)
            SZ_BYTE: rdata = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: rdata = rword;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// Synchronous MIPS-32 data memory with valid/ready requests, pulsed responses and
// WAIT_STATES extra cycles. Define DMEM_MISALIGN_CHECK_EN to flag misaligned/reserved accesses.
module data_memory_unit
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_unit_if.slave bus,
    output dmem_state_t   dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH];

    logic              ready;
    logic              accept;
    logic              enter_resp;
    dmem_req_t         cur_req;
    logic [ADDR_W-1:0] cur_addr;
    logic              err;
    logic [1:0]        eff_size;
    logic [1:0]        eff_off;
    logic [3:0]        be;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rword;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;
    logic              mem_we;
    logic              unused_addr_hi;

    assign ready  = rst_n && (state_q == IDLE || state_q == RESP);
    assign accept = bus.req_valid && ready;

    // State register and captured request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            addr_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                else        state_d = IDLE;
            end
            WAIT: begin
                if (cnt_q == 4'(WAIT_STATES - 1)) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT && state_d == WAIT) cnt_d = cnt_q + 4'd1;
        req_d  = req_q;
        addr_d = addr_q;
        if (accept) begin
            req_d  = '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                       wdata: bus.req_wdata};
            addr_d = bus.req_addr;
        end
    end

    // Without wait states the access completes on its own accept edge, so it
    // must use the live bus fields rather than the captured copy.
    always_comb begin
        if (state_q == WAIT) begin
            cur_req  = req_q;
            cur_addr = addr_q;
        end else begin
            cur_req  = '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                         wdata: bus.req_wdata};
            cur_addr = bus.req_addr;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        err      = (cur_req.size == SZ_RSVD) ||
                   (cur_req.size == SZ_HALF && cur_addr[0]) ||
                   (cur_req.size == SZ_WORD && cur_addr[1:0] != 2'b00);
        eff_size = cur_req.size;
        eff_off  = cur_addr[1:0];
    end
`else
    always_comb begin
        err      = 1'b0;
        eff_size = (cur_req.size == SZ_RSVD) ? SZ_WORD : cur_req.size;
        eff_off  = cur_addr[1:0];
        if (eff_size == SZ_HALF) eff_off = {cur_addr[1], 1'b0};
        if (eff_size == SZ_WORD) eff_off = 2'b00;
    end
`endif

    assign enter_resp     = (state_d == RESP);
    assign idx            = cur_addr[IDX_W+1:2];
    assign be             = byte_en(eff_size, eff_off);
    assign rword          = mem[idx];
    assign mem_we         = rst_n && enter_resp && cur_req.we && !err;
    assign unused_addr_hi = ^cur_addr[ADDR_W-1:IDX_W+2];

    dmem_lane_align u_lane_align (
        .size       (eff_size),
        .offset     (eff_off),
        .uns        (cur_req.uns),
        .wdata      (cur_req.wdata),
        .rword      (rword),
        .lane_wdata (lane_wdata),
        .rdata      (load_data)
    );

    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_err_d   = err;
            rsp_rdata_d = (cur_req.we || err) ? 32'h0 : load_data;
        end
    end

    // Array is deliberately not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && be[i]) mem[idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
        end
    end

    // Output logic
    always_comb begin
        bus.req_ready = ready;
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit with WAIT_STATES=3; misaligned-access
// expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_data_memory_unit;
    import mips_mem_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 18;
    localparam int WS     = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    dmem_state_t dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    data_memory_unit_if #(.ADDR_W(ADDR_W)) bus ();

    data_memory_unit #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is high.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard = 0;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = k;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] e;
        exp_q.push_back(exp_rd);
        access(we, sz, uns, addr, wd, rd, er, lat);
        e = exp_q.pop_front();
        check({tag, "_rdata"}, rd, e);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    endtask

    initial begin
        int pulses;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);

        // 1. Reset during WAIT drops the store
        run("t1_init", 1'b1, SZ_WORD, 1'b0, 18'h40, 32'h11111111, 32'h0, 1'b0);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = SZ_WORD;
        bus.req_addr     = 18'h40;
        bus.req_wdata    = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_in_wait", {30'b0, dbg_state}, {30'b0, WAIT});
        rst_n = 1'b0;
        #1;
        check("t1_rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
        check("t1_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_ready", {31'b0, bus.req_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) pulses++;
        end
        check("t1_no_rsp", 32'(pulses), 32'd0);
        run("t1_lw_old", 1'b0, SZ_WORD, 1'b0, 18'h40, 32'h0, 32'h11111111, 1'b0);

        // 2. Word path and single-cycle pulse
        run("t2_sw", 1'b1, SZ_WORD, 1'b0, 18'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        run("t2_lw", 1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("t2_pulse_end", {31'b0, bus.rsp_valid}, 32'd0);
        check("t2_rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);
        run("t2_lw_uns", 1'b0, SZ_WORD, 1'b1, 18'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // 3. Bytes
        run("t3_sb", 1'b1, SZ_BYTE, 1'b0, 18'h13, 32'h123456A5, 32'h0, 1'b0);
        run("t3_lb", 1'b0, SZ_BYTE, 1'b0, 18'h13, 32'h0, 32'hFFFFFFA5, 1'b0);
        run("t3_lbu", 1'b0, SZ_BYTE, 1'b1, 18'h13, 32'h0, 32'h000000A5, 1'b0);
        run("t3_lw", 1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0, 32'hA5ADBEEF, 1'b0);
        run("t3_lb0", 1'b0, SZ_BYTE, 1'b0, 18'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
        run("t3_lbu1", 1'b0, SZ_BYTE, 1'b1, 18'h11, 32'h0, 32'h000000BE, 1'b0);

        // 4. Halves
        run("t4_sw", 1'b1, SZ_WORD, 1'b0, 18'h20, 32'h11223344, 32'h0, 1'b0);
        run("t4_sh", 1'b1, SZ_HALF, 1'b0, 18'h22, 32'hFFFF8001, 32'h0, 1'b0);
        run("t4_lh", 1'b0, SZ_HALF, 1'b0, 18'h22, 32'h0, 32'hFFFF8001, 1'b0);
        run("t4_lhu", 1'b0, SZ_HALF, 1'b1, 18'h22, 32'h0, 32'h00008001, 1'b0);
        run("t4_lw", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0, 32'h80013344, 1'b0);

        // 5. Misaligned and reserved size
`ifdef DMEM_MISALIGN_CHECK_EN
        run("t5_lw_mis", 1'b0, SZ_WORD, 1'b0, 18'h11, 32'h0, 32'h0, 1'b1);
        run("t5_sh_mis", 1'b1, SZ_HALF, 1'b0, 18'h21, 32'h00007F02, 32'h0, 1'b1);
        run("t5_lw_chk", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0, 32'h80013344, 1'b0);
        run("t5_rsvd", 1'b0, SZ_RSVD, 1'b0, 18'h10, 32'h0, 32'h0, 1'b1);
        run("t5_sw_rsvd", 1'b1, SZ_RSVD, 1'b0, 18'h20, 32'h55555555, 32'h0, 1'b1);
        run("t5_lw_chk2", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0, 32'h80013344, 1'b0);
`else
        run("t5_lw_mis", 1'b0, SZ_WORD, 1'b0, 18'h11, 32'h0, 32'hA5ADBEEF, 1'b0);
        run("t5_sh_mis", 1'b1, SZ_HALF, 1'b0, 18'h21, 32'h00007F02, 32'h0, 1'b0);
        run("t5_lw_chk", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0, 32'h80017F02, 1'b0);
        run("t5_rsvd", 1'b0, SZ_RSVD, 1'b0, 18'h10, 32'h0, 32'hA5ADBEEF, 1'b0);
        run("t5_lh_mis", 1'b0, SZ_HALF, 1'b1, 18'h23, 32'h0, 32'h00008001, 1'b0);
`endif

        // 6. Back-to-back with address wrap
        run("t6_sw_wrap", 1'b1, SZ_WORD, 1'b0, 18'(DEPTH * 4), 32'hCAFEF00D, 32'h0, 1'b0);
        check("t6_ready_resp", {31'b0, bus.req_ready}, 32'd1);
        run("t6_lw0", 1'b0, SZ_WORD, 1'b0, 18'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        check("t6_ready_end", {31'b0, bus.req_ready}, 32'd1);
        run("t6_lw_t2", 1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0, 32'hA5ADBEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
